ace_snoop_responder: RTL and testbench

//   Cache-side end of the CCU snoop path: accepts ACE snoop requests (AC), looks up the local dcache,

---
 rtl/ccu_pkg.sv | 98 +++++++++
 rtl/ace_cd_serializer.sv | 56 +++++
 rtl/ace_snoop_responder.sv | 182 ++++++++++++++++++
 tb/tb_ace_snoop_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ccu_pkg.sv
// Shared CCU snoop types: ACSNOOP opcodes, CR response layout, cache update ops, responder FSM states,
// and the snoop decision helper.
package ccu_pkg;

  typedef enum logic [3:0] {
    SnpReadOnce           = 4'b0000,
    SnpReadShared         = 4'b0001,
    SnpReadClean          = 4'b0010,
    SnpReadNotSharedDirty = 4'b0011,
    SnpReadUnique         = 4'b0111,
    SnpCleanShared        = 4'b1000,
    SnpCleanInvalid       = 4'b1001,
    SnpMakeInvalid        = 4'b1101
  } snoop_e;

  typedef struct packed {
    logic wasUnique;
    logic isShared;
    logic passDirty;
    logic error;
    logic dataTransfer;
  } crresp_t;

  typedef enum logic [1:0] {
    UpdNone        = 2'b00,
    UpdCleanShared = 2'b01,
    UpdInvalidate  = 2'b10
  } cache_upd_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StLookup = 2'b01,
    StWait   = 2'b10,
    StResp   = 2'b11
  } snoop_state_e;

  typedef struct packed {
    crresp_t       resp;
    logic          upd;
    cache_upd_op_e op;
  } snoop_decision_t;

  // A miss always answers with an all-zero response and leaves the cache untouched.
  function automatic snoop_decision_t snoopDecide(input logic [3:0] snoop, input logic hit,
                                                  input logic dirty, input logic shared);
    snoop_decision_t d;
    d = '0;
    if (hit) begin
      d.resp.wasUnique = !shared;
      case (snoop)
        SnpReadOnce: begin
          d.resp.dataTransfer = 1'b1;
          d.resp.isShared     = 1'b1;
        end
        SnpReadShared, SnpReadClean, SnpReadNotSharedDirty: begin
          d.resp.dataTransfer = 1'b1;
          d.resp.isShared     = 1'b1;
          d.resp.passDirty    = dirty;
          d.upd               = dirty;
          d.op                = dirty ? UpdCleanShared : UpdNone;
        end
        SnpReadUnique: begin
          d.resp.dataTransfer = 1'b1;
          d.resp.passDirty    = dirty;
          d.upd               = 1'b1;
          d.op                = UpdInvalidate;
        end
        SnpCleanInvalid: begin
          d.resp.dataTransfer = dirty;
          d.resp.passDirty    = dirty;
          d.upd               = 1'b1;
          d.op                = UpdInvalidate;
        end
        SnpCleanShared: begin
          d.resp.dataTransfer = dirty;
          d.resp.passDirty    = dirty;
          d.resp.isShared     = 1'b1;
          d.upd               = dirty;
          d.op                = dirty ? UpdCleanShared : UpdNone;
        end
        SnpMakeInvalid: begin
          d.upd = 1'b1;
          d.op  = UpdInvalidate;
        end
        default: begin
          d.resp       = '0;
          d.resp.error = 1'b1;
          d.upd        = 1'b0;
          d.op         = UpdNone;
        end
      endcase
    end else begin
      d = '0;
    end
    return d;
  endfunction

endpackage

// File: rtl/ace_cd_serializer.sv
// Splits a registered cache line into DataWidth CD beats (beat 0 = low bits) with valid/ready
// handshaking and a registered last flag.
module ace_cd_serializer #(
  parameter int DataWidth = 64,
  parameter int LineWidth = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [LineWidth-1:0] line_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 last_o
);
  import ccu_pkg::*;

  localparam int NumBeats = LineWidth / DataWidth;
  localparam int CntW = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NumBeats - 1);

  logic [LineWidth-1:0] lineQ;
  logic [CntW-1:0]      beatCnt;
  logic                 validQ;
  logic                 lastQ;

  // Beat shifter: the current beat always sits in the low DataWidth bits of lineQ.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lineQ   <= '0;
      beatCnt <= '0;
      validQ  <= 1'b0;
      lastQ   <= 1'b0;
    end else if (load_i) begin
      lineQ   <= line_i;
      beatCnt <= '0;
      validQ  <= 1'b1;
      lastQ   <= (NumBeats == 1);
    end else if (validQ && ready_i) begin
      lineQ <= lineQ >> DataWidth;
      if (lastQ) begin
        validQ  <= 1'b0;
        beatCnt <= '0;
        lastQ   <= 1'b0;
      end else begin
        beatCnt <= beatCnt + CntW'(1);
        lastQ   <= ((beatCnt + CntW'(1)) == LastIdx);
      end
    end
  end

  assign valid_o = validQ;
  assign data_o  = lineQ[DataWidth-1:0];
  assign last_o  = lastQ;

endmodule

// File: rtl/ace_snoop_responder.sv
// Answers ACE snoops: one snoop in flight, dcache lookup, CR response and optional CD line data.
// Optional hit/miss statistics counters are built when ACE_SNOOP_STATS_EN is defined.
module ace_snoop_responder
  import ccu_pkg::*;
#(
  parameter int AddrWidth       = 64,
  parameter int DataWidth       = 64,
  parameter int DcacheLineWidth = 128
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       ac_valid_i,
  output logic                       ac_ready_o,
  input  logic [AddrWidth-1:0]       ac_addr_i,
  input  logic [3:0]                 ac_snoop_i,
  output logic                       cr_valid_o,
  input  logic                       cr_ready_i,
  output logic [4:0]                 cr_resp_o,
  output logic                       cd_valid_o,
  input  logic                       cd_ready_i,
  output logic [DataWidth-1:0]       cd_data_o,
  output logic                       cd_last_o,
  output logic                       cache_req_o,
  input  logic                       cache_gnt_i,
  output logic [AddrWidth-1:0]       cache_addr_o,
  input  logic                       cache_rvalid_i,
  input  logic                       cache_hit_i,
  input  logic                       cache_dirty_i,
  input  logic                       cache_shared_i,
  input  logic [DcacheLineWidth-1:0] cache_line_i,
  output logic                       cache_upd_o,
  output logic [1:0]                 cache_upd_op_o
`ifdef ACE_SNOOP_STATS_EN
  ,
  output logic [31:0]                snoop_hit_cnt_o,
  output logic [31:0]                snoop_miss_cnt_o
`endif
);

  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(DcacheLineWidth / 8 - 1);

  snoop_state_e    state;
  logic            acReady;
  logic [3:0]      acSnoopQ;
  logic            cacheReq;
  logic [AddrWidth-1:0] cacheAddr;
  logic            crValid;
  crresp_t         crResp;
  logic            crDone;
  logic            cdDone;
  logic            cacheUpd;
  cache_upd_op_e   cacheUpdOp;
  snoop_decision_t dec;
  logic            cdLoad;
  logic            crFire;
  logic            cdLastFire;

  // Snoop decision from the live lookup result; only consumed on the rvalid cycle.
  always_comb begin
    dec = snoopDecide(acSnoopQ, cache_hit_i, cache_dirty_i, cache_shared_i);
  end

  assign cdLoad     = (state == StWait) && cache_rvalid_i && dec.resp.dataTransfer;
  assign crFire     = crValid && cr_ready_i;
  assign cdLastFire = cd_valid_o && cd_ready_i && cd_last_o;

  // Snoop FSM; acReady comes up one cycle after reset release so nothing is accepted in reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= StIdle;
      acReady    <= 1'b0;
      acSnoopQ   <= 4'b0000;
      cacheReq   <= 1'b0;
      cacheAddr  <= '0;
      crValid    <= 1'b0;
      crResp     <= '0;
      crDone     <= 1'b0;
      cdDone     <= 1'b0;
      cacheUpd   <= 1'b0;
      cacheUpdOp <= UpdNone;
    end else begin
      case (state)
        StIdle: begin
          if (acReady && ac_valid_i) begin
            acReady   <= 1'b0;
            acSnoopQ  <= ac_snoop_i;
            cacheAddr <= ac_addr_i & AlignMask;
            cacheReq  <= 1'b1;
            state     <= StLookup;
          end else begin
            acReady <= 1'b1;
          end
        end
        StLookup: begin
          if (cache_gnt_i) begin
            cacheReq <= 1'b0;
            state    <= StWait;
          end else begin
            cacheReq <= 1'b1;
          end
        end
        StWait: begin
          if (cache_rvalid_i) begin
            crValid    <= 1'b1;
            crResp     <= dec.resp;
            crDone     <= 1'b0;
            cdDone     <= !dec.resp.dataTransfer;
            cacheUpd   <= dec.upd;
            cacheUpdOp <= dec.upd ? dec.op : UpdNone;
            state      <= StResp;
          end else begin
            state <= StWait;
          end
        end
        StResp: begin
          cacheUpd   <= 1'b0;
          cacheUpdOp <= UpdNone;
          if (crFire) begin
            crValid <= 1'b0;
          end
          if ((crDone || crFire) && (cdDone || cdLastFire)) begin
            crDone  <= 1'b0;
            cdDone  <= 1'b0;
            acReady <= 1'b1;
            state   <= StIdle;
          end else begin
            crDone <= crDone || crFire;
            cdDone <= cdDone || cdLastFire;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  ace_cd_serializer #(
    .DataWidth (DataWidth),
    .LineWidth (DcacheLineWidth)
  ) u_cd_serializer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (cdLoad),
    .line_i  (cache_line_i),
    .valid_o (cd_valid_o),
    .ready_i (cd_ready_i),
    .data_o  (cd_data_o),
    .last_o  (cd_last_o)
  );

  assign ac_ready_o     = acReady;
  assign cr_valid_o     = crValid;
  assign cr_resp_o      = crResp;
  assign cache_req_o    = cacheReq;
  assign cache_addr_o   = cacheAddr;
  assign cache_upd_o    = cacheUpd;
  assign cache_upd_op_o = cacheUpdOp;

`ifdef ACE_SNOOP_STATS_EN
  logic [31:0] hitCnt;
  logic [31:0] missCnt;

  // Saturating hit/miss counters, one count per accepted lookup result.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hitCnt  <= 32'd0;
      missCnt <= 32'd0;
    end else if ((state == StWait) && cache_rvalid_i) begin
      if (cache_hit_i) begin
        if (hitCnt != 32'hFFFF_FFFF) hitCnt <= hitCnt + 32'd1;
      end else begin
        if (missCnt != 32'hFFFF_FFFF) missCnt <= missCnt + 32'd1;
      end
    end
  end

  assign snoop_hit_cnt_o  = hitCnt;
  assign snoop_miss_cnt_o = missCnt;
`endif

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: drives AC and cache-side handshakes on the falling edge
// and checks CR/CD/update outputs against hand-computed values.
module tb_ace_snoop_responder;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         ac_valid_i;
  logic         ac_ready_o;
  logic [63:0]  ac_addr_i;
  logic [3:0]   ac_snoop_i;
  logic         cr_valid_o;
  logic         cr_ready_i;
  logic [4:0]   cr_resp_o;
  logic         cd_valid_o;
  logic         cd_ready_i;
  logic [63:0]  cd_data_o;
  logic         cd_last_o;
  logic         cache_req_o;
  logic         cache_gnt_i;
  logic [63:0]  cache_addr_o;
  logic         cache_rvalid_i;
  logic         cache_hit_i;
  logic         cache_dirty_i;
  logic         cache_shared_i;
  logic [127:0] cache_line_i;
  logic         cache_upd_o;
  logic [1:0]   cache_upd_op_o;
`ifdef ACE_SNOOP_STATS_EN
  logic [31:0]  snoop_hit_cnt_o;
  logic [31:0]  snoop_miss_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] Addr        = 64'h0000_1234_5678_9ABF;
  localparam logic [63:0] AddrAligned = 64'h0000_1234_5678_9AB0;

  always #5 clk = ~clk;

  ace_snoop_responder dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .ac_valid_i     (ac_valid_i),
    .ac_ready_o     (ac_ready_o),
    .ac_addr_i      (ac_addr_i),
    .ac_snoop_i     (ac_snoop_i),
    .cr_valid_o     (cr_valid_o),
    .cr_ready_i     (cr_ready_i),
    .cr_resp_o      (cr_resp_o),
    .cd_valid_o     (cd_valid_o),
    .cd_ready_i     (cd_ready_i),
    .cd_data_o      (cd_data_o),
    .cd_last_o      (cd_last_o),
    .cache_req_o    (cache_req_o),
    .cache_gnt_i    (cache_gnt_i),
    .cache_addr_o   (cache_addr_o),
    .cache_rvalid_i (cache_rvalid_i),
    .cache_hit_i    (cache_hit_i),
    .cache_dirty_i  (cache_dirty_i),
    .cache_shared_i (cache_shared_i),
    .cache_line_i   (cache_line_i),
    .cache_upd_o    (cache_upd_o),
    .cache_upd_op_o (cache_upd_op_o)
`ifdef ACE_SNOOP_STATS_EN
    ,
    .snoop_hit_cnt_o  (snoop_hit_cnt_o),
    .snoop_miss_cnt_o (snoop_miss_cnt_o)
`endif
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitAcReady();
    int n;
    n = 0;
    while (ac_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkVal("acReadyWait", {63'd0, ac_ready_o}, 64'd1);
  endtask

  // Issue one snoop, walk the lookup and check the response/data phase.
  task automatic runSnoop(input logic [3:0] op, input logic hit, input logic dirty, input logic shared,
                          input logic [127:0] line, input logic [4:0] expResp, input logic expUpd,
                          input logic [1:0] expOp, input logic expDt, input logic [63:0] exp0,
                          input logic [63:0] exp1, input int crDelay, input bit cdToggle,
                          input bit preReady);
    bit crDone;
    bit cdDone;
    int beat;
    waitAcReady();
    ac_valid_i = 1'b1;
    ac_addr_i  = Addr;
    ac_snoop_i = op;
    @(negedge clk);
    ac_valid_i = 1'b0;
    cr_ready_i = preReady;
    cd_ready_i = preReady;
    checkVal("lookupReq", {63'd0, cache_req_o}, 64'd1);
    checkVal("lookupAddr", cache_addr_o, AddrAligned);
    checkVal("acReadyBusyLookup", {63'd0, ac_ready_o}, 64'd0);
    @(negedge clk);
    checkVal("lookupReqHeld", {63'd0, cache_req_o}, 64'd1);
    cache_gnt_i = 1'b1;
    @(negedge clk);
    cache_gnt_i = 1'b0;
    checkVal("reqDropAfterGnt", {63'd0, cache_req_o}, 64'd0);
    checkVal("noEarlyCr", {63'd0, cr_valid_o}, 64'd0);
    checkVal("noEarlyCd", {63'd0, cd_valid_o}, 64'd0);
    cache_rvalid_i = 1'b1;
    cache_hit_i    = hit;
    cache_dirty_i  = dirty;
    cache_shared_i = shared;
    cache_line_i   = line;
    @(negedge clk);
    cache_rvalid_i = 1'b0;
    cache_line_i   = '0;
    crDone = 1'b0;
    cdDone = !expDt;
    beat   = 0;
    for (int cyc = 0; cyc < 60 && !(crDone && cdDone); cyc++) begin
      cr_ready_i = (cyc >= crDelay);
      cd_ready_i = cdToggle ? (cyc % 2 == 1) : 1'b1;
      checkVal("updPulse", {63'd0, cache_upd_o}, (cyc == 0) ? {63'd0, expUpd} : 64'd0);
      if (cyc == 0) checkVal("updOp", {62'd0, cache_upd_op_o}, {62'd0, expOp});
      if (!crDone) begin
        checkVal("crValid", {63'd0, cr_valid_o}, 64'd1);
        checkVal("crResp", {59'd0, cr_resp_o}, {59'd0, expResp});
        if (cr_ready_i) crDone = 1'b1;
      end
      if (!cdDone) begin
        checkVal("cdValid", {63'd0, cd_valid_o}, 64'd1);
        if (cd_ready_i) begin
          checkVal("cdData", cd_data_o, (beat == 0) ? exp0 : exp1);
          checkVal("cdLast", {63'd0, cd_last_o}, (beat == 1) ? 64'd1 : 64'd0);
          beat++;
          if (beat == 2) cdDone = 1'b1;
        end
      end else begin
        checkVal("cdIdle", {63'd0, cd_valid_o}, 64'd0);
      end
      checkVal("acReadyBusy", {63'd0, ac_ready_o}, 64'd0);
      @(negedge clk);
    end
    cr_ready_i = 1'b0;
    cd_ready_i = 1'b0;
    checkVal("respDone", {63'd0, crDone && cdDone}, 64'd1);
    checkVal("acReadyAfterResp", {63'd0, ac_ready_o}, 64'd1);
    checkVal("crValidAfterResp", {63'd0, cr_valid_o}, 64'd0);
    checkVal("cdValidAfterResp", {63'd0, cd_valid_o}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = 4'b0000;
    cr_ready_i = 1'b0; cd_ready_i = 1'b0;
    cache_gnt_i = 1'b0; cache_rvalid_i = 1'b0;
    cache_hit_i = 1'b0; cache_dirty_i = 1'b0; cache_shared_i = 1'b0; cache_line_i = '0;
    repeat (3) @(negedge clk);
    checkVal("rstAcReady", {63'd0, ac_ready_o}, 64'd0);
    checkVal("rstCrValid", {63'd0, cr_valid_o}, 64'd0);
    checkVal("rstCdValid", {63'd0, cd_valid_o}, 64'd0);
    checkVal("rstReq", {63'd0, cache_req_o}, 64'd0);
    checkVal("rstUpd", {63'd0, cache_upd_o}, 64'd0);
    checkVal("rstCrResp", {59'd0, cr_resp_o}, 64'd0);
    checkVal("rstCdData", cd_data_o, 64'd0);
    rst_ni = 1'b1;

    // ReadShared, hit dirty shared
    runSnoop(4'b0001, 1'b1, 1'b1, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_88A5,
             5'b01101, 1'b1, 2'b01, 1'b1, 64'h5555_6666_7777_88A5, 64'h1111_2222_3333_4444,
             0, 1'b0, 1'b0);
    // ReadUnique, hit clean unique, readies high before valid
    runSnoop(4'b0111, 1'b1, 1'b0, 1'b0, 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002,
             5'b10001, 1'b1, 2'b10, 1'b1, 64'hCAFE_F00D_0000_0002, 64'hDEAD_BEEF_0000_0001,
             0, 1'b0, 1'b1);
    // ReadClean miss
    runSnoop(4'b0010, 1'b0, 1'b1, 1'b0, 128'h0,
             5'b00000, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0, 0, 1'b0, 1'b0);
    // Unsupported opcode, hit, CR held off 5 cycles
    runSnoop(4'b0101, 1'b1, 1'b1, 1'b0, 128'h0,
             5'b00010, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0, 5, 1'b0, 1'b0);
    // CleanInvalid, hit dirty unique, CD toggling after CR
    runSnoop(4'b1001, 1'b1, 1'b1, 1'b0, 128'hAAAA_BBBB_CCCC_DDDD_0123_4567_89AB_CDEF,
             5'b10101, 1'b1, 2'b10, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hAAAA_BBBB_CCCC_DDDD,
             0, 1'b1, 1'b0);
    // MakeInvalid, hit clean shared
    runSnoop(4'b1101, 1'b1, 1'b0, 1'b1, 128'h0,
             5'b00000, 1'b1, 2'b10, 1'b0, 64'h0, 64'h0, 0, 1'b0, 1'b0);
    // CleanShared, hit clean unique
    runSnoop(4'b1000, 1'b1, 1'b0, 1'b0, 128'h0,
             5'b11000, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0, 0, 1'b0, 1'b0);
    // ReadOnce, hit dirty unique, CR late and CD toggling
    runSnoop(4'b0000, 1'b1, 1'b1, 1'b0, 128'h0F0F_0F0F_0F0F_0F0F_F0F0_F0F0_F0F0_F0F0,
             5'b11001, 1'b0, 2'b00, 1'b1, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
             3, 1'b1, 1'b0);

    // Reset while waiting for the lookup result
    waitAcReady();
    ac_valid_i = 1'b1; ac_addr_i = Addr; ac_snoop_i = 4'b0001;
    @(negedge clk);
    ac_valid_i = 1'b0;
    cache_gnt_i = 1'b1;
    @(negedge clk);
    cache_gnt_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk);
    checkVal("midRstAcReady", {63'd0, ac_ready_o}, 64'd0);
    checkVal("midRstReq", {63'd0, cache_req_o}, 64'd0);
    checkVal("midRstCrValid", {63'd0, cr_valid_o}, 64'd0);
    checkVal("midRstCdValid", {63'd0, cd_valid_o}, 64'd0);
    checkVal("midRstUpd", {63'd0, cache_upd_o}, 64'd0);
`ifdef ACE_SNOOP_STATS_EN
    checkVal("midRstHitCnt", {32'd0, snoop_hit_cnt_o}, 64'd0);
    checkVal("midRstMissCnt", {32'd0, snoop_miss_cnt_o}, 64'd0);
`endif
    rst_ni = 1'b1;
    @(negedge clk);
    checkVal("postRstCrValid", {63'd0, cr_valid_o}, 64'd0);
    checkVal("postRstCdValid", {63'd0, cd_valid_o}, 64'd0);

    // Normal operation resumes after the mid-flight reset
    runSnoop(4'b0011, 1'b1, 1'b1, 1'b0, 128'h9999_8888_7777_6666_5555_4444_3333_2222,
             5'b11101, 1'b1, 2'b01, 1'b1, 64'h5555_4444_3333_2222, 64'h9999_8888_7777_6666,
             1, 1'b0, 1'b0);
`ifdef ACE_SNOOP_STATS_EN
    checkVal("hitCnt", {32'd0, snoop_hit_cnt_o}, 64'd1);
    checkVal("missCnt", {32'd0, snoop_miss_cnt_o}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
